// File: rtl/arithmetic_logic_unit.sv
// MIPS-style datapath ALU: eight operations, zero flag, one-stage registered copy.
// Optional signed-overflow detection and sticky flag are enabled by `ALU_OVERFLOW_EN.
module arithmetic_logic_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q,
  output logic             overflow,
  output logic             overflow_sticky
);

  typedef enum logic [2:0] {
    OP_SLT  = 3'b000,
    OP_SUB  = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOR  = 3'b011,
    OP_SLTU = 3'b100,
    OP_ADD  = 3'b101,
    OP_OR   = 3'b110,
    OP_AND  = 3'b111
  } alu_op_e;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt_signed;
  logic             lt_unsigned;

  assign sum         = a + b;
  assign diff        = a - b;
  // SLT uses a true signed compare so it stays correct when a - b wraps.
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  always_comb begin
    result = '0;
    case (alucontrol)
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SUB:  result = diff;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_ADD:  result = sum;
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      default: result = '0;
    endcase
  end

  assign zero = ~|result;

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result;
      zero_q   <= zero;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf_add;
  logic ovf_sub;
  logic overflow_sticky_q;
  logic overflow_sticky_d;

  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    overflow = 1'b0;
    if (alucontrol == OP_ADD) overflow = ovf_add;
    else if (alucontrol == OP_SUB) overflow = ovf_sub;
  end

  assign overflow_sticky_d = overflow_sticky_q | overflow;

  // Reset takes priority over an overflow seen on the same edge.
  always_ff @(posedge clk) begin
    if (reset) overflow_sticky_q <= 1'b0;
    else       overflow_sticky_q <= overflow_sticky_d;
  end

  assign overflow_sticky = overflow_sticky_q;
`else
  assign overflow        = 1'b0;
  assign overflow_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Bench for arithmetic_logic_unit: directed and random vectors, reference model,
// expected-value queues drained by monitors on the combinational and registered paths.
module tb_arithmetic_logic_unit;
  localparam int W  = 32;
  localparam int EW = W + 2;

  logic         clk;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   alucontrol;
  logic [W-1:0] result;
  logic         zero;
  logic [W-1:0] result_q;
  logic         zero_q;
  logic         overflow;
  logic         overflow_sticky;

  arithmetic_logic_unit #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .a               (a),
    .b               (b),
    .alucontrol      (alucontrol),
    .result          (result),
    .zero            (zero),
    .result_q        (result_q),
    .zero_q          (zero_q),
    .overflow        (overflow),
    .overflow_sticky (overflow_sticky)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_reg_q[$];
  int checks_total  = 0;
  int checks_passed = 0;
  logic model_sticky = 1'b0;

  // reference model: {result, zero, overflow}
  function automatic logic [EW-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    longint sx, sy, s, hi, lo;
    logic [W-1:0] r;
    logic ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    hi  = 64'sd2147483647;
    lo  = -64'sd2147483648;
    ovf = 1'b0;
    r   = '0;
    case (op)
      3'd0: r = (sx < sy) ? 1 : 0;
      3'd1: begin
        r = x - y;
        s = sx - sy;
        ovf = (s > hi) || (s < lo);
      end
      3'd2: r = x ^ y;
      3'd3: r = ~(x | y);
      3'd4: r = ({32'd0, x} < {32'd0, y}) ? 1 : 0;
      3'd5: begin
        r = x + y;
        s = sx + sy;
        ovf = (s > hi) || (s < lo);
      end
      3'd6: r = x | y;
      default: r = x & y;
    endcase
`ifndef ALU_OVERFLOW_EN
    ovf = 1'b0;
`endif
    return {r, (r == '0), ovf};
  endfunction

  // driver: one vector per cycle, applied shortly after the rising edge
  task automatic drive(input logic rst, input logic [2:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    logic [EW-1:0] e;
    @(posedge clk);
    #2;
    reset      = rst;
    alucontrol = op;
    a          = x;
    b          = y;
    e = ref_alu(op, x, y);
    exp_q.push_back(e);
    if (rst) model_sticky = 1'b0;
    else     model_sticky = model_sticky | e[0];
    if (rst) exp_reg_q.push_back({{W{1'b0}}, 1'b1, 1'b0});
    else     exp_reg_q.push_back({e[EW-1:2], e[1], model_sticky});
  endtask

  // monitor: combinational outputs, mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e, g;
      e = exp_q.pop_front();
      g = {result, zero, overflow};
      checks_total++;
      if (g === e) checks_passed++;
      else $display("FAIL comb op=%0d a=%h b=%h got {res,zero,ovf}=%h/%b/%b want %h/%b/%b",
                    alucontrol, a, b, g[EW-1:2], g[1], g[0], e[EW-1:2], e[1], e[0]);
    end
  end

  // monitor: registered outputs, just after the edge that captured them
  always @(posedge clk) begin
    #1;
    if (exp_reg_q.size() > 0) begin
      logic [EW-1:0] e, g;
      e = exp_reg_q.pop_front();
      g = {result_q, zero_q, overflow_sticky};
      checks_total++;
      if (g === e) checks_passed++;
      else $display("FAIL reg got {res_q,zero_q,sticky}=%h/%b/%b want %h/%b/%b",
                    g[EW-1:2], g[1], g[0], e[EW-1:2], e[1], e[0]);
    end
  end

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    reset = 1'b1; a = '0; b = '0; alucontrol = 3'd0;
    // reset state
    drive(1'b1, 3'd5, 32'd0, 32'd0);
    // SLT / SLTU
    drive(1'b0, 3'd0, 32'd12, 32'd25);
    drive(1'b0, 3'd0, 32'd52, 32'd25);
    drive(1'b0, 3'd0, 32'd25, 32'd25);
    drive(1'b0, 3'd0, 32'hFFFF_FFFF, 32'd1);
    drive(1'b0, 3'd4, 32'hFFFF_FFFF, 32'd1);
    // SUB
    drive(1'b0, 3'd1, 32'd25, 32'd25);
    drive(1'b0, 3'd1, 32'd15, 32'd25);
    drive(1'b0, 3'd1, 32'd25, 32'd15);
    drive(1'b0, 3'd1, 32'h8000_0000, 32'd1);
    // ADD, sticky must hold across the non-overflow vectors that follow
    drive(1'b0, 3'd5, 32'd25, 32'd25);
    drive(1'b0, 3'd5, 32'd0, 32'd25);
    drive(1'b0, 3'd5, 32'd25, 32'd0);
    drive(1'b0, 3'd5, 32'h7FFF_FFFF, 32'd1);
    drive(1'b0, 3'd5, 32'hFFFF_FFFF, 32'd1);
    // logic ops
    drive(1'b0, 3'd6, 32'd25, 32'd0);
    drive(1'b0, 3'd6, 32'd0, 32'd25);
    drive(1'b0, 3'd6, 32'd0, 32'd0);
    drive(1'b0, 3'd6, 32'd23, 32'd23);
    drive(1'b0, 3'd7, 32'd25, 32'd0);
    drive(1'b0, 3'd7, 32'd25, 32'd25);
    drive(1'b0, 3'd7, 32'd0, 32'd0);
    drive(1'b0, 3'd2, 32'hF0, 32'hFF);
    drive(1'b0, 3'd3, 32'd0, 32'd0);
    // reset on the same edge as an overflow, then overflow again
    drive(1'b1, 3'd5, 32'h7FFF_FFFF, 32'd1);
    drive(1'b0, 3'd5, 32'd25, 32'd25);
    drive(1'b0, 3'd1, 32'h8000_0000, 32'd1);
    drive(1'b0, 3'd6, 32'd1, 32'd2);
    drive(1'b1, 3'd6, 32'd1, 32'd2);
    // random
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)), pick_operand(),
            pick_operand());
    end
    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0 || exp_reg_q.size() != 0) begin
      checks_total++;
      $display("FAIL drain comb_left=%0d reg_left=%0d want 0/0", exp_q.size(), exp_reg_q.size());
    end
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
